lcplc_stream_sequencer: RTL

Front-end controller for the LCPLC coder. It accepts a per-image configuration (slice geometry, band and slice counts, quantizer shift, threshold) through a handshake. It then forwards the raw sample stream to the coder, generating the row/slice/band/image last flags from counters, and holds the coder configuration stable until the coder has emitted its final output word. It sits between the sample source (DMA/AXIS) and the `LCPLC` instance.

---
 rtl/lcplc_seq_pkg.sv | 27 ++
 rtl/lcplc_wrap_counter.sv | 26 ++
 rtl/lcplc_stream_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lcplc_seq_pkg.sv
// Shared types for the LCPLC stream sequencer: field widths, FSM states and the
// latched per-image configuration.
package lcplc_seq_pkg;

    localparam int unsigned DATA_WIDTH            = 16;
    localparam int unsigned DIM_WIDTH             = 4;
    localparam int unsigned BAND_WIDTH            = 8;
    localparam int unsigned SLICE_WIDTH           = 16;
    localparam int unsigned QUANTIZER_SHIFT_WIDTH = 4;
    localparam int unsigned THRESHOLD_WIDTH       = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIM_WIDTH-1:0]             cols_m1;
        logic [DIM_WIDTH-1:0]             rows_m1;
        logic [BAND_WIDTH-1:0]            bands_m1;
        logic [SLICE_WIDTH-1:0]           slices_m1;
        logic [QUANTIZER_SHIFT_WIDTH-1:0] quant_shift;
        logic [THRESHOLD_WIDTH-1:0]       threshold;
    } cfg_t;

endpackage

// File: rtl/lcplc_wrap_counter.sv
// Position counter that wraps to zero after reaching a programmable maximum.
module lcplc_wrap_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] max,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    assign at_max = (count == max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/lcplc_stream_sequencer.sv
// Front-end sequencer for the LCPLC coder: latches per-image config, forwards samples and
// derives row/slice/band/image last flags. Define LCPLC_SEQ_TLAST_CHECK_EN to check s_last.
module lcplc_stream_sequencer
    import lcplc_seq_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [DIM_WIDTH-1:0]             cfg_cols_m1,
    input  logic [DIM_WIDTH-1:0]             cfg_rows_m1,
    input  logic [BAND_WIDTH-1:0]            cfg_bands_m1,
    input  logic [SLICE_WIDTH-1:0]           cfg_slices_m1,
    input  logic [QUANTIZER_SHIFT_WIDTH-1:0] cfg_quant_shift,
    input  logic [THRESHOLD_WIDTH-1:0]       cfg_threshold,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_last,
    output logic                             x_valid,
    input  logic                             x_ready,
    output logic [DATA_WIDTH-1:0]            x_data,
    output logic                             x_last_r,
    output logic                             x_last_s,
    output logic                             x_last_b,
    output logic                             x_last_i,
    output logic [QUANTIZER_SHIFT_WIDTH-1:0] coder_quant_shift,
    output logic [THRESHOLD_WIDTH-1:0]       coder_threshold,
    input  logic                             mon_valid,
    input  logic                             mon_ready,
    input  logic                             mon_last,
    output logic                             busy,
    output logic                             image_done,
    output logic                             tlast_err
);

    state_t state, state_nxt;
    cfg_t   cfg_q, cfg_nxt;
    logic   image_done_nxt;
    logic   run, beat, cfg_hs, mon_final;
    logic   col_max, row_max, band_max, slice_max;

    logic [DIM_WIDTH-1:0]   col_cnt, row_cnt;
    logic [BAND_WIDTH-1:0]  band_cnt;
    logic [SLICE_WIDTH-1:0] slice_cnt;

    assign run       = (state == RUN);
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign mon_final = mon_valid && mon_ready && mon_last;

    // Zero-latency pass-through, gated to RUN; s_ready follows x_ready only.
    assign x_valid = run && s_valid;
    assign s_ready = run && x_ready;
    assign x_data  = s_data;
    assign beat    = x_valid && x_ready;

    assign x_last_r = run && col_max;
    assign x_last_s = x_last_r && row_max;
    assign x_last_b = x_last_s && band_max;
    assign x_last_i = x_last_b && slice_max;

    assign coder_quant_shift = cfg_q.quant_shift;
    assign coder_threshold   = cfg_q.threshold;

    // Column innermost, then row, band, slice.
    lcplc_wrap_counter #(.WIDTH(DIM_WIDTH)) u_col (
        .clk(clk), .rst(rst), .max(cfg_q.cols_m1), .clr(cfg_hs),
        .en(beat), .count(col_cnt), .at_max(col_max)
    );

    lcplc_wrap_counter #(.WIDTH(DIM_WIDTH)) u_row (
        .clk(clk), .rst(rst), .max(cfg_q.rows_m1), .clr(cfg_hs),
        .en(beat && col_max), .count(row_cnt), .at_max(row_max)
    );

    lcplc_wrap_counter #(.WIDTH(BAND_WIDTH)) u_band (
        .clk(clk), .rst(rst), .max(cfg_q.bands_m1), .clr(cfg_hs),
        .en(beat && col_max && row_max), .count(band_cnt), .at_max(band_max)
    );

    lcplc_wrap_counter #(.WIDTH(SLICE_WIDTH)) u_slice (
        .clk(clk), .rst(rst), .max(cfg_q.slices_m1), .clr(cfg_hs),
        .en(beat && col_max && row_max && band_max), .count(slice_cnt), .at_max(slice_max)
    );

    // Only the wrap flags matter to the sequencer; raw counts stay internal.
    logic unused_cnt;
    assign unused_cnt = ^{col_cnt, row_cnt, band_cnt, slice_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q      <= '0;
            image_done <= 1'b0;
        end else begin
            cfg_q      <= cfg_nxt;
            image_done <= image_done_nxt;
        end
    end

    // A final coder beat coinciding with the last input beat is still honoured, and FLUSH
    // holds for the image_done cycle so cfg_ready rises only afterwards.
    always_comb begin
        state_nxt      = state;
        cfg_nxt        = cfg_q;
        image_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    cfg_nxt.cols_m1     = cfg_cols_m1;
                    cfg_nxt.rows_m1     = cfg_rows_m1;
                    cfg_nxt.bands_m1    = cfg_bands_m1;
                    cfg_nxt.slices_m1   = cfg_slices_m1;
                    cfg_nxt.quant_shift = cfg_quant_shift;
                    cfg_nxt.threshold   = cfg_threshold;
                    state_nxt           = RUN;
                end
            end
            RUN: begin
                if (beat && x_last_i) begin
                    state_nxt      = FLUSH;
                    image_done_nxt = mon_final;
                end
            end
            FLUSH: begin
                if (image_done) begin
                    state_nxt = IDLE;
                end else begin
                    image_done_nxt = mon_final;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LCPLC_SEQ_TLAST_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlast_err <= 1'b0;
        end else if (beat && (s_last != x_last_i)) begin
            tlast_err <= 1'b1;
        end
    end
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign tlast_err     = 1'b0;
`endif

endmodule
